systolic_tile_scheduler: RTL



---
 rtl/systolic_tile_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler: clears the systolic array, streams k_len operand reads, waits out the skew, then holds the result for a handshake.
// Revision 1.0
`default_nettype none

module systolic_tile_scheduler #(
  parameter int HIDDEN_SIZE    = 2,
  parameter int CONTEXT_LENGTH = 4,
  parameter int K_MAX          = 256,
  parameter int ADDR_W         = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   k_len,
  output logic              busy,
  output logic              err,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic              array_clear,
  output logic              feed_valid,
  output logic              array_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  // Skew depth through the array plus one cycle of buffer read latency.
  localparam int                DRAIN_CYC  = HIDDEN_SIZE + CONTEXT_LENGTH;
  localparam int                DCNT_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [ADDR_W:0]   K_MAX_L    = (ADDR_W + 1)'(K_MAX);
  localparam logic [ADDR_W:0]   KLEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic [ADDR_W:0]   klen, klen_nxt;
  logic              fv_q, err_q, done_q;
  logic              err_nxt, done_nxt;
  logic              rd_en;
  logic              len_ok;
  logic              feed_last;

  assign len_ok    = (k_len != '0) && (k_len <= K_MAX_L);
  assign feed_last = ({1'b0, cnt} == (klen - KLEN_ONE));

  always_ff @(posedge clock) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      klen   <= '0;
      fv_q   <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dcnt   <= dcnt_nxt;
      klen   <= klen_nxt;
      fv_q   <= rd_en;
      err_q  <= err_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dcnt_nxt    = dcnt;
    klen_nxt    = klen;
    err_nxt     = 1'b0;
    done_nxt    = 1'b0;
    rd_en       = 1'b0;
    busy        = 1'b1;
    array_clear = 1'b0;
    out_valid   = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len_ok) begin
            klen_nxt  = k_len;
            state_nxt = S_CLEAR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        array_clear = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = S_FEED;
      end
      S_FEED: begin
        rd_en = 1'b1;
        if (feed_last) begin
          cnt_nxt   = '0;
          dcnt_nxt  = '0;
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          dcnt_nxt  = '0;
          state_nxt = S_OUTPUT;
        end else begin
          dcnt_nxt = dcnt + DCNT_ONE;
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_rd_en    = rd_en;
  assign x_rd_en    = rd_en;
  assign w_rd_addr  = rd_en ? cnt : '0;
  assign x_rd_addr  = rd_en ? cnt : '0;
  assign feed_valid = fv_q;
  assign array_en   = fv_q | (state == S_DRAIN);
  assign err        = err_q;
  assign done       = done_q;

endmodule

`default_nettype wire
